snake_mover: RTL
================

# snake_mover

Snake body engine for the snake game. It consumes the one-cycle game-step pulse produced by the step-rate divider and advances the snake one grid cell per pulse. It holds the head direction, a body of up to MAX_LEN segments and pending growth, and detects wall and self collision. It also provides a registered segment-hit query port for the VGA renderer.

## Interface
Parameters:
- GRID_W, 40, grid width in cells; legal x is 0..GRID_W-1
- GRID_H, 30, grid height in cells; legal y is 0..GRID_H-1
- X_W, 6, x coordinate width
- Y_W, 5, y coordinate width
- MAX_LEN, 16, segment capacity (at least INIT_LEN)
- INIT_LEN, 3, length after start (at least 2)
- WRAP, 0, selects edge behaviour: 1 = wrap around, 0 = wall kills

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle step pulse from the divider
- start  in  1  pulse; (re)initialises the snake from IDLE or DEAD
- dir_valid  in  1  qualifies dir_req
- dir_req  in  2  requested direction: 0 right, 1 up (y-1), 2 left, 3 down (y+1)
- grow  in  1  pulse; food eaten
- qx  in  X_W  query x
- qy  in  Y_W  query y
- q_hit  out  1  registered; (qx,qy) is occupied by a live segment
- head_x  out  X_W  head x
- head_y  out  Y_W  head y
- length  out  $clog2(MAX_LEN+1)  live segment count
- dead  out  1  high while in DEAD
- step_done  out  1  one-cycle pulse when positions update

## Operation
- States:
  - IDLE: reset state; tick is ignored.
  - RUN: the snake moves.
  - DEAD: latched game over; tick is ignored.
- Transitions:
  - IDLE → RUN and DEAD → RUN on start.
  - RUN → DEAD on collision.
  - start during RUN reinitialises and stays in RUN.
- Init on start:
  - seg[0] (head) = (GRID_W/2, GRID_H/2), and seg[i] = (GRID_W/2 - i, GRID_H/2).
  - length = INIT_LEN, dir = 0, pending_dir = 0, grow_pending = 0.
- Direction handling:
  - dir_valid loads pending_dir = dir_req unless dir_req == dir ^ 2; a reverse request is dropped.
  - On a tick, dir takes pending_dir as sampled before that cycle. A request arriving in the same cycle as the tick applies to the next tick.
- Growth:
  - grow sets grow_pending.
  - A step consumes (grow_pending | grow) and clears it.
  - When length == MAX_LEN, growth is discarded: length is unchanged and the flag is cleared.
- Step on tick in RUN:
  - nh = seg[0] + delta(pending_dir).
  - WRAP=1: x wraps GRID_W-1 ↔ 0 and y wraps GRID_H-1 ↔ 0, modulo grid size, not modulo 2^width.
  - WRAP=0: leaving the grid is a collision.
  - Self collision: nh equals any seg[i] for i < length. When not growing, the tail index length-1 is excluded because it vacates the cell.
  - On collision: go to DEAD. Positions, length and dir are frozen and step_done does not pulse.
  - Otherwise: seg[i] ← seg[i-1] for i ≥ 1, seg[0] ← nh, and length += 1 if growing (capped at MAX_LEN).
- Segments with index ≥ length are don't-care and never match queries or collisions.
- Query: q_hit ← OR over i < length of (seg[i] == (qx,qy)). Evaluated every cycle in all states; length 0 gives 0.

## Timing
- Reset values: state IDLE, head_x = 0, head_y = 0, length = 0, dead = 0, step_done = 0, q_hit = 0. Reset is asynchronous and valid mid-RUN.
- Tick to update: the tick is sampled at edge N; head_x, head_y, length and step_done change at edge N+1, so step latency is 1 cycle.
- Start to update: start at edge N gives initial positions and RUN at N+1. start has priority over a same-cycle tick; that tick is ignored.
- dead rises one cycle after the colliding tick.
- q_hit latency is 1 cycle and reflects segment state at the sampling edge.
- tick is assumed at least 2 cycles apart; back-to-back ticks must each perform a step.

## Test plan
- Reset, then start → length = 3, head = (20,15); the queries (19,15) and (18,15) give q_hit = 1, and (17,15) gives 0.
- Two ticks 10 cycles apart, no direction requests → head_x = 21 then 22, step_done high exactly one cycle after each tick, and q_hit(19,15) = 0 after the second step.
- dir_req = 2 then tick → reverse is dropped and head_x increments. dir_req = 1 then tick → head_y decrements by 1.
- grow pulse then tick → length = 4 and the old tail cell is still hit. grow with length = MAX_LEN → length stays at MAX_LEN.
- WRAP=0 with the head driven to x = 39 moving right, then tick → dead = 1 and head_x stays 39; a later start returns to init. WRAP=1, same stimulus → head_x = 0 and dead = 0.
- length 5 with steps up, left, down → dead = 1 on the third tick. Assert rst mid-RUN → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/snake_mover.sv
// Snake body engine: advances the snake one cell per game-step tick, tracks growth,
// detects wall/self collision and answers a registered segment-hit query.
module snake_mover #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir_req,
  input  logic                           grow,
  input  logic [X_W-1:0]                 qx,
  input  logic [Y_W-1:0]                 qy,
  output logic                           q_hit,
  output logic [X_W-1:0]                 head_x,
  output logic [Y_W-1:0]                 head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           dead,
  output logic                           step_done
);

  localparam int L_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] seg_x_q [MAX_LEN];
  logic [X_W-1:0] seg_x_d [MAX_LEN];
  logic [Y_W-1:0] seg_y_q [MAX_LEN];
  logic [Y_W-1:0] seg_y_d [MAX_LEN];
  logic [L_W-1:0] len_q, len_d;
  logic [1:0]     dir_q, dir_d, pdir_q, pdir_d;
  logic           grow_q, grow_d, step_q, step_d, hit_q, hit_d;

  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic           wall, self_hit, growing, grow_eff, collide;

  // Candidate head position; the wrapped value is used only when WRAP is set.
  always_comb begin
    nx   = seg_x_q[0];
    ny   = seg_y_q[0];
    wall = 1'b0;
    case (pdir_q)
      2'd0: begin
        if (seg_x_q[0] == X_W'(GRID_W - 1)) begin
          nx   = '0;
          wall = 1'b1;
        end else nx = seg_x_q[0] + X_W'(1);
      end
      2'd1: begin
        if (seg_y_q[0] == '0) begin
          ny   = Y_W'(GRID_H - 1);
          wall = 1'b1;
        end else ny = seg_y_q[0] - Y_W'(1);
      end
      2'd2: begin
        if (seg_x_q[0] == '0) begin
          nx   = X_W'(GRID_W - 1);
          wall = 1'b1;
        end else nx = seg_x_q[0] - X_W'(1);
      end
      default: begin
        if (seg_y_q[0] == Y_W'(GRID_H - 1)) begin
          ny   = '0;
          wall = 1'b1;
        end else ny = seg_y_q[0] + Y_W'(1);
      end
    endcase
  end

  assign growing  = grow_q | grow;
  assign grow_eff = growing && (len_q != L_W'(MAX_LEN));

  // The tail cell vacates on a non-growing step, so it cannot be hit.
  always_comb begin
    self_hit = 1'b0;
    hit_d    = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (L_W'(i) < len_q) begin
        if ((grow_eff || (L_W'(i) != len_q - L_W'(1))) &&
            seg_x_q[i] == nx && seg_y_q[i] == ny) begin
          self_hit = 1'b1;
        end
        if (seg_x_q[i] == qx && seg_y_q[i] == qy) hit_d = 1'b1;
      end
    end
  end

  assign collide = self_hit || (wall && (WRAP == 0));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dir_d   = dir_q;
    pdir_d  = pdir_q;
    grow_d  = grow_q;
    step_d  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end
    if (start) begin
      for (int i = 0; i < INIT_LEN; i++) begin
        seg_x_d[i] = X_W'(GRID_W / 2 - i);
        seg_y_d[i] = Y_W'(GRID_H / 2);
      end
      len_d   = L_W'(INIT_LEN);
      dir_d   = 2'd0;
      pdir_d  = 2'd0;
      grow_d  = 1'b0;
      state_d = StRun;
    end else if (state_q == StRun) begin
      if (tick) begin
        if (collide) begin
          state_d = StDead;
          grow_d  = growing;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nx;
          seg_y_d[0] = ny;
          dir_d      = pdir_q;
          if (grow_eff) len_d = len_q + L_W'(1);
          grow_d     = 1'b0;
          step_d     = 1'b1;
        end
      end else if (grow) begin
        grow_d = 1'b1;
      end
      if (dir_valid && (dir_req != (dir_q ^ 2'd2))) pdir_d = dir_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      dir_q   <= '0;
      pdir_q  <= '0;
      grow_q  <= 1'b0;
      step_q  <= 1'b0;
      hit_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      pdir_q  <= pdir_d;
      grow_q  <= grow_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  assign q_hit     = hit_q;
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign dead      = (state_q == StDead);
  assign step_done = step_q;

endmodule
